// File: rtl/rgb_seq_pkg.sv
// Shared types and constants for the RGB fade sequencer: FSM states, the colour
// program, the gamma table and the per-channel step function.
package rgb_seq_pkg;

    typedef enum logic [1:0] {IDLE, FADE, HOLD} state_t;

    localparam int PROG_W = 6;

    typedef struct packed {
        logic [PROG_W-1:0] r;
        logic [PROG_W-1:0] g;
        logic [PROG_W-1:0] b;
    } rgb_t;

    // Entry 0 is the least significant element.
    localparam rgb_t [7:0] COLOUR_PROG = {
        {6'd0,  6'd0,  6'd0 },
        {6'd63, 6'd63, 6'd63},
        {6'd63, 6'd0,  6'd63},
        {6'd0,  6'd63, 6'd63},
        {6'd63, 6'd63, 6'd0 },
        {6'd0,  6'd0,  6'd63},
        {6'd0,  6'd63, 6'd0 },
        {6'd63, 6'd0,  6'd0 }
    };

    // Square-law perceptual correction, rounded: g(x) = (x*x + 31) / 63.
    function automatic logic [63:0][PROG_W-1:0] gamma_build();
        logic [63:0][PROG_W-1:0] tbl;
        for (int i = 0; i < 64; i++)
            tbl[i] = PROG_W'((i * i + 31) / 63);
        return tbl;
    endfunction

    localparam logic [63:0][PROG_W-1:0] GAMMA_TBL = gamma_build();

    function automatic logic [15:0] step_toward(input logic [15:0] cur,
                                                input logic [15:0] tgt);
        if (cur < tgt)
            return cur + 16'd1;
        else if (cur > tgt)
            return cur - 16'd1;
        else
            return cur;
    endfunction

endpackage

// File: rtl/rgb_tick_gen.sv
// Button synchronizer and run-gated prescaler producing the fade tick.
module rgb_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic run,
    output logic tick
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic          btn_meta;
    logic          btn_sync;
    logic [CW-1:0] presc;
    logic          wrap;

    assign wrap = (presc == CW'(TICK_DIV - 1));

    // The prescaler freezes while paused so a resume keeps the same tick phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            presc    <= '0;
        end else begin
            btn_meta <= btn;
            btn_sync <= btn_meta;
            if (btn_sync)
                presc <= wrap ? '0 : presc + CW'(1);
        end
    end

    assign run  = btn_sync;
    assign tick = btn_sync && wrap;

endmodule

// File: rtl/rgb_fade_seq.sv
// RGB colour-program fade sequencer driving the per-channel PWM duties.
// Optional RGB_GAMMA_EN adds a registered gamma lookup stage on the duty outputs.
module rgb_fade_seq import rgb_seq_pkg::*; #(
    parameter int DUTY_W     = 6,
    parameter int TICK_DIV   = 50000,
    parameter int HOLD_TICKS = 500
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn,
    output logic [DUTY_W-1:0] duty_r,
    output logic [DUTY_W-1:0] duty_g,
    output logic [DUTY_W-1:0] duty_b,
    output logic              duty_vld,
    output logic [2:0]        step_idx,
    output logic              busy
);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    logic              run, tick;
    state_t            state, state_nxt;
    logic [HW-1:0]     hold_cnt, hold_nxt, hold_inc;
    logic [2:0]        step_nxt;
    logic [DUTY_W-1:0] lin_r, lin_g, lin_b;
    logic [DUTY_W-1:0] nxt_r, nxt_g, nxt_b;
    logic [DUTY_W-1:0] tgt_r, tgt_g, tgt_b;
    logic              lin_vld, at_tgt;

    rgb_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .run   (run),
        .tick  (tick)
    );

    assign tgt_r    = DUTY_W'(COLOUR_PROG[step_idx].r);
    assign tgt_g    = DUTY_W'(COLOUR_PROG[step_idx].g);
    assign tgt_b    = DUTY_W'(COLOUR_PROG[step_idx].b);
    assign at_tgt   = (lin_r == tgt_r) && (lin_g == tgt_g) && (lin_b == tgt_b);
    assign hold_inc = hold_cnt + HW'(1);

    // Ticks only occur while running, so pause freezes everything implicitly.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        step_nxt  = step_idx;
        nxt_r     = lin_r;
        nxt_g     = lin_g;
        nxt_b     = lin_b;
        case (state)
            IDLE: if (run) state_nxt = FADE;
            FADE: if (tick) begin
                if (at_tgt) begin
                    state_nxt = HOLD;
                    hold_nxt  = '0;
                end else begin
                    nxt_r = DUTY_W'(step_toward(16'(lin_r), 16'(tgt_r)));
                    nxt_g = DUTY_W'(step_toward(16'(lin_g), 16'(tgt_g)));
                    nxt_b = DUTY_W'(step_toward(16'(lin_b), 16'(tgt_b)));
                end
            end
            HOLD: if (tick) begin
                hold_nxt = hold_inc;
                if (hold_inc == HW'(HOLD_TICKS)) begin
                    state_nxt = FADE;
                    step_nxt  = step_idx + 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            step_idx <= '0;
            lin_r    <= '0;
            lin_g    <= '0;
            lin_b    <= '0;
            lin_vld  <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            step_idx <= step_nxt;
            lin_r    <= nxt_r;
            lin_g    <= nxt_g;
            lin_b    <= nxt_b;
            lin_vld  <= (nxt_r != lin_r) || (nxt_g != lin_g) || (nxt_b != lin_b);
        end
    end

    assign busy = (state != IDLE);

`ifdef RGB_GAMMA_EN
    logic [DUTY_W-1:0] gam_r, gam_g, gam_b;
    logic [DUTY_W-1:0] gin_r, gin_g, gin_b;
    logic              gam_vld;

    assign gin_r = DUTY_W'(GAMMA_TBL[PROG_W'(lin_r)]);
    assign gin_g = DUTY_W'(GAMMA_TBL[PROG_W'(lin_g)]);
    assign gin_b = DUTY_W'(GAMMA_TBL[PROG_W'(lin_b)]);

    // Valid tracks changes after correction; flat regions of the curve emit no pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            gam_r   <= '0;
            gam_g   <= '0;
            gam_b   <= '0;
            gam_vld <= 1'b0;
        end else begin
            gam_r   <= gin_r;
            gam_g   <= gin_g;
            gam_b   <= gin_b;
            gam_vld <= (gin_r != gam_r) || (gin_g != gam_g) || (gin_b != gam_b);
        end
    end

    assign duty_r   = gam_r;
    assign duty_g   = gam_g;
    assign duty_b   = gam_b;
    assign duty_vld = gam_vld;
`else
    assign duty_r   = lin_r;
    assign duty_g   = lin_g;
    assign duty_b   = lin_b;
    assign duty_vld = lin_vld;
`endif

endmodule
